// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared processor definitions: immediate-format codes (ImmSrc), RV32I major
// opcodes, the buffered word layout and a sign-extension range helper. The
// decode-side immediate extender uses the same format codes, so the encoder
// and the decoder always agree on what each ImmSrc value means.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    // Immediate format selector; 3'b110 and 3'b111 are illegal.
    typedef enum logic [2:0] {
        IMM_R = 3'b000,
        IMM_I = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_U = 3'b100,
        IMM_J = 3'b101
    } imm_src_e;

    // RV32I major opcodes.
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Output buffer depth.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    // One buffered entry: the error flag travels alongside its word.
    typedef struct packed {
        logic        imm_err;
        logic [31:0] instr;
    } enc_word_t;

    // True when value[31:msb] are all equal, i.e. the value is the sign
    // extension of a (msb+1)-bit two's-complement number.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((value & mask) == mask) || ((value & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational RV32I field packer with immediate range checking.
// Ports:
//   imm_src  in  3   format code (instr_encoder_pkg::imm_src_e)
//   opcode   in  7   opcode field
//   rd/rs1/rs2 in 5  register fields
//   funct3   in  3,  funct7 in 7
//   imm      in  32  full signed immediate (byte offset for B/J)
//   instr    out 32  encoded word (0 for an illegal format)
//   imm_err  out 1   immediate not representable, or format illegal
// -----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        imm_err
);

    // Format-directed packing. A legal format with an out-of-range immediate
    // still produces the truncated encoding; only the flag reports the problem.
    // B and J offsets must be even because bit 0 is implicit in the encoding.
    always_comb begin
        instr   = 32'h0;
        imm_err = 1'b0;
        case (imm_src)
            IMM_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            IMM_I: begin
                instr   = {imm[11:0], rs1, funct3, rd, opcode};
                imm_err = !fits_signed(imm, 11);
            end
            IMM_S: begin
                instr   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_err = !fits_signed(imm, 11);
            end
            IMM_B: begin
                instr   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_err = !fits_signed(imm, 12) || imm[0];
            end
            IMM_U: begin
                instr   = {imm[31:12], rd, opcode};
                imm_err = |imm[11:0];
            end
            IMM_J: begin
                instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                imm_err = !fits_signed(imm, 20) || imm[0];
            end
            default: begin
                instr   = 32'h0;
                imm_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Encodes RV32I field sets into instruction words and buffers them in a
// 2-entry FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready depends only on occupancy)
//   ImmSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, Imm   field set
//   out_valid/out_ready output handshake
//   InstrOut, ImmErr    oldest buffered word and its error sideband
//   EncCount            saturating count of delivered words
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  ImmSrc,
    input  logic [6:0]  Opcode,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [2:0]  Funct3,
    input  logic [6:0]  Funct7,
    input  logic [31:0] Imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] InstrOut,
    output logic        ImmErr,
    output logic [15:0] EncCount
);

    logic [31:0] pack_instr;
    logic        pack_err;
    enc_word_t   mem [0:1];
    enc_word_t   head;
    logic [1:0]  occupancy;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;

    instr_pack u_pack (
        .imm_src (ImmSrc),
        .opcode  (Opcode),
        .rd      (Rd),
        .rs1     (Rs1),
        .rs2     (Rs2),
        .funct3  (Funct3),
        .funct7  (Funct7),
        .imm     (Imm),
        .instr   (pack_instr),
        .imm_err (pack_err)
    );

    // in_ready is a pure function of occupancy, so there is no combinational
    // path from out_ready back to the producer.
    assign in_ready  = (occupancy < FIFO_DEPTH);
    assign out_valid = (occupancy != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage carries no reset; the occupancy gating below keeps stale
    // entries invisible after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{imm_err: pack_err, instr: pack_instr};
        end
    end

    // Pointers, occupancy and the delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
            EncCount  <= 16'h0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (EncCount != 16'hFFFF) begin
                    EncCount <= EncCount + 16'h1;
                end
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Present the oldest entry; force zeros while empty so reset shows 0.
    assign head     = mem[rd_ptr];
    assign InstrOut = out_valid ? head.instr   : 32'h0;
    assign ImmErr   = out_valid ? head.imm_err : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder. A queue-based model computes expected
// words from the RV32I field rules with integer arithmetic; a negedge compare
// process checks the DUT against it, and directed checks pin known encodings.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ImmSrc = 3'b0;
    logic [6:0]  Opcode = 7'b0;
    logic [4:0]  Rd = 5'b0;
    logic [4:0]  Rs1 = 5'b0;
    logic [4:0]  Rs2 = 5'b0;
    logic [2:0]  Funct3 = 3'b0;
    logic [6:0]  Funct7 = 7'b0;
    logic [31:0] Imm = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] InstrOut;
    logic        ImmErr;
    logic [15:0] EncCount;

    int          pass_count = 0;
    int          check_count = 0;
    logic        checking = 1'b0;
    logic [32:0] exp_q [$];
    logic [15:0] exp_count = 16'h0;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .Opcode    (Opcode),
        .Rd        (Rd),
        .Rs1       (Rs1),
        .Rs2       (Rs2),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .Imm       (Imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .InstrOut  (InstrOut),
        .ImmErr    (ImmErr),
        .EncCount  (EncCount)
    );

    always #5 clk = ~clk;

    // Expected {ImmErr, InstrOut} from the field rules, using integer ranges
    // for representability rather than bit patterns.
    function automatic logic [32:0] model_encode(input logic [2:0] src, input logic [6:0] op,
                                                 input logic [4:0] rd, input logic [4:0] rs1,
                                                 input logic [4:0] rs2, input logic [2:0] f3,
                                                 input logic [6:0] f7, input logic [31:0] imm);
        longint      s;
        logic [31:0] w;
        logic        err;
        s   = longint'($signed(imm));
        w   = 32'h0;
        err = 1'b0;
        case (src)
            3'd0: w = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: begin
                w   = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | ((imm & 32'hFFF) << 20);
                err = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w   = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
                err = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w   = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
                err = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            3'd4: begin
                w   = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
                err = (s % 4096 != 0);
            end
            3'd5: begin
                w   = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 20) & 32'h1) << 31);
                err = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            default: begin
                w   = 32'h0;
                err = 1'b1;
            end
        endcase
        return {err, w};
    endfunction

    // Model of the buffer: accept when fewer than two are held, deliver the
    // oldest when the consumer is ready; reset empties it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_count <= 16'h0;
        end else if (in_valid && exp_q.size() < 2) begin
            if (out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_count <= (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'h1;
            end
            exp_q.push_back(model_encode(ImmSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, Imm));
        end else if (out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_count <= (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'h1;
        end
    end

    task automatic checkOutput(input string name, input logic [32:0] got, input logic [32:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every negedge: handshake flags, counter and the head word against the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("in_ready", {32'h0, in_ready}, {32'h0, exp_q.size() < 2});
            checkOutput("out_valid", {32'h0, out_valid}, {32'h0, exp_q.size() != 0});
            checkOutput("enc_count", {17'h0, EncCount}, {17'h0, exp_count});
            if (exp_q.size() != 0) begin
                checkOutput("head_word", {ImmErr, InstrOut}, exp_q[0]);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
        @(negedge clk);
        ImmSrc   = src;
        Opcode   = op;
        Rd       = rd;
        Rs1      = rs1;
        Rs2      = rs2;
        Funct3   = f3;
        Funct7   = f7;
        Imm      = imm;
        in_valid = 1'b1;
    endtask

    // Drop in_valid and scramble the fields, which must then be ignored.
    task automatic goIdle();
        @(negedge clk);
        in_valid = 1'b0;
        ImmSrc   = 3'($urandom);
        Opcode   = 7'($urandom);
        Rd       = 5'($urandom);
        Rs1      = 5'($urandom);
        Rs2      = 5'($urandom);
        Imm      = $urandom;
    endtask

    task automatic doReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        out_ready = 1'b1;
        #12;
        checkOutput("reset_out_valid", {32'h0, out_valid}, 33'h0);
        checkOutput("reset_in_ready", {32'h0, in_ready}, 33'h1);
        checkOutput("reset_word", {ImmErr, InstrOut}, 33'h0);
        checkOutput("reset_count", {17'h0, EncCount}, 33'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;

        // Single words, consumer always ready.
        applyStimulus(IMM_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        @(posedge clk); #1;
        checkOutput("i_latency", {32'h0, out_valid}, 33'h1);
        checkOutput("i_word", {ImmErr, InstrOut}, {1'b0, 32'h0050_0093});
        applyStimulus(IMM_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        @(posedge clk); #1;
        checkOutput("s_word", {ImmErr, InstrOut}, {1'b0, 32'h0020_A423});
        applyStimulus(IMM_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
        @(posedge clk); #1;
        checkOutput("u_word", {ImmErr, InstrOut}, {1'b0, 32'h1234_52B7});
        applyStimulus(IMM_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
        @(posedge clk); #1;
        checkOutput("j_word", {ImmErr, InstrOut}, {1'b0, 32'h0080_00EF});
        applyStimulus(IMM_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
        @(posedge clk); #1;
        checkOutput("b_odd_err", {32'h0, ImmErr}, 33'h1);
        applyStimulus(3'b111, OP_OP, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
        @(posedge clk); #1;
        checkOutput("illegal_fmt", {ImmErr, InstrOut}, {1'b1, 32'h0});
        applyStimulus(IMM_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
        @(posedge clk); #1;
        checkOutput("i_overflow", {ImmErr, InstrOut}, {1'b1, 32'h8000_0093});
        // Boundary and negative values, checked by the model only.
        applyStimulus(IMM_I, OP_IMM, 5'd2, 5'd3, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800);
        applyStimulus(IMM_B, OP_BRANCH, 5'd0, 5'd4, 5'd5, 3'b001, 7'd0, 32'hFFFF_F000);
        applyStimulus(IMM_B, OP_BRANCH, 5'd0, 5'd4, 5'd5, 3'b001, 7'd0, 32'd4096);
        applyStimulus(IMM_J, OP_JAL, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h000F_FFFE);
        applyStimulus(IMM_J, OP_JAL, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0010_0000);
        applyStimulus(IMM_U, OP_LUI, 5'd9, 5'd0, 5'd0, 3'b000, 7'd0, 32'hABCD_E001);
        applyStimulus(IMM_S, OP_STORE, 5'd0, 5'd6, 5'd7, 3'b000, 7'd0, 32'hFFFF_FFFC);
        goIdle();
        goIdle();

        // Backpressure: three back-to-back sets while the consumer stalls.
        doReset();
        out_ready = 1'b0;
        applyStimulus(IMM_R, OP_OP, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0);
        applyStimulus(IMM_R, OP_OP, 5'd4, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0);
        @(posedge clk); #1;
        checkOutput("full_in_ready", {32'h0, in_ready}, 33'h0);
        applyStimulus(IMM_I, OP_IMM, 5'd6, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        checkOutput("held_in_ready", {32'h0, in_ready}, 33'h0);
        checkOutput("held_head", {ImmErr, InstrOut}, {1'b0, 32'h0020_81B3});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("order_2nd", {ImmErr, InstrOut}, {1'b0, 32'h4020_8233});
        @(posedge clk); #1;
        checkOutput("order_3rd", {ImmErr, InstrOut}, {1'b0, 32'hFFF0_0313});
        goIdle();
        @(posedge clk); #1;
        checkOutput("bp_count", {17'h0, EncCount}, 33'd3);
        checkOutput("bp_drained", {32'h0, out_valid}, 33'h0);

        // Steady streaming at occupancy 1.
        out_ready = 1'b0;
        applyStimulus(IMM_I, OP_IMM, 5'd10, 5'd0, 5'd0, 3'b000, 7'd0, 32'd100);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(IMM_I, OP_IMM, 5'(i + 11), 5'(i), 5'd0, 3'b000, 7'd0, 32'(i * 7));
            @(posedge clk); #1;
            checkOutput("stream_occ1", {31'h0, in_ready, out_valid}, 33'b11);
        end
        goIdle();
        @(posedge clk); #1;
        checkOutput("stream_count", {17'h0, EncCount}, 33'd14);

        // Reset with two entries buffered, then accept on the first edge.
        out_ready = 1'b0;
        applyStimulus(IMM_U, OP_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_1000);
        applyStimulus(IMM_U, OP_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_2000);
        goIdle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {32'h0, out_valid}, 33'h0);
        checkOutput("midrst_count", {17'h0, EncCount}, 33'h0);
        checkOutput("midrst_in_ready", {32'h0, in_ready}, 33'h1);
        checkOutput("midrst_word", {ImmErr, InstrOut}, 33'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ImmSrc    = IMM_I;
        Opcode    = OP_IMM;
        Rd        = 5'd1;
        Rs1       = 5'd0;
        Rs2       = 5'd0;
        Funct3    = 3'b000;
        Funct7    = 7'd0;
        Imm       = 32'd5;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_accept", {out_valid, InstrOut}, {1'b1, 32'h0050_0093});
        goIdle();
        @(posedge clk); #1;
        checkOutput("post_rst_count", {17'h0, EncCount}, 33'd1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1, rst_n input 1.
REQ-002 SHALL have ports, one per line as name direction width meaning:
- in_valid  input 1  field set valid
- in_ready  output 1  encoder can accept
- ImmSrc  input 3  format: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110/111 illegal
- Opcode  input 7  opcode field
- Rd, Rs1, Rs2  input 5 each  register fields
- Funct3  input 3; Funct7 input 7
- Imm  input 32  full signed immediate value, byte offset for B/J
- out_valid  output 1  encoded word valid
- out_ready  input 1  consumer accepts
- InstrOut  output 32  encoded RV32I word
- ImmErr  output 1  sideband for InstrOut: immediate not representable or format illegal
- EncCount  output 16  words delivered

Function
REQ-003 SHALL pack fields per RV32I: Opcode[6:0], Rd[11:7] for R/I/U/J, Funct3[14:12] for R/I/S/B, Rs1[19:15] for R/I/S/B, Rs2[24:20] for R/S/B, Funct7[31:25] for R.
REQ-004 SHALL place immediates as follows.
- I: Imm[11:0] -> [31:20].
- S: Imm[11:5] -> [31:25], Imm[4:0] -> [11:7].
- B: Imm[12] -> [31], Imm[10:5] -> [30:25], Imm[4:1] -> [11:8], Imm[11] -> [7].
- U: Imm[31:12] -> [31:12].
- J: Imm[20] -> [31], Imm[10:1] -> [30:21], Imm[11] -> [20], Imm[19:12] -> [19:12].
REQ-005 SHALL set ImmErr as follows.
- I/S: Imm[31:11] not all equal.
- B: Imm[31:12] not all equal, or Imm[0]=1.
- U: Imm[11:0] != 0.
- J: Imm[31:20] not all equal, or Imm[0]=1.
- R: never set.
- Illegal ImmSrc: set, and InstrOut = 0.
REQ-006 SHALL still emit the truncated encoding when ImmErr=1 for a legal format; the error never blocks the handshake.
REQ-007 SHALL buffer encoded words in a 2-entry FIFO; entry = {ImmErr, InstrOut}.
REQ-008 SHALL drive in_ready = (occupancy < 2), with no combinational path from out_ready.
REQ-009 SHALL accept a field set on a clk edge where in_valid && in_ready, and deliver it on an edge where out_valid && out_ready.
REQ-010 SHALL drive out_valid = (occupancy != 0); InstrOut/ImmErr SHALL present the oldest entry and hold stable while out_valid && !out_ready.
REQ-011 SHALL have a latency of 1 cycle: a set accepted at edge N with an empty FIFO appears with out_valid=1 after edge N.
REQ-012 SHALL handle simultaneous push and pop at occupancy 1 with occupancy staying 1 and order preserved; push at occupancy 2 is impossible by REQ-008; pop at occupancy 0 is impossible.
REQ-013 SHALL preserve strict FIFO order; read and write pointers are 1 bit each and wrap.
REQ-014 SHALL increment EncCount on every delivery and saturate at 16'hFFFF.
REQ-015 SHALL ignore all input fields when in_valid=0.

Reset
REQ-016 SHALL, on rst_n low, asynchronously clear occupancy, pointers and EncCount, driving out_valid=0, in_ready=1, InstrOut=0 and ImmErr=0.
REQ-017 SHALL discard buffered entries on reset mid-operation, with no partial delivery after release.
REQ-018 SHALL accept input on the first clk edge after rst_n deasserts.

Structure
REQ-019 SHALL take the ImmSrc format codes and RV32I opcode constants from the shared processor package, which is also used by the decode-side immediate extender.
REQ-020 SHALL isolate pure field packing and range checks in one combinational sub-module, instr_pack; instr_encoder adds the FIFO, handshake and counter.

Verification
REQ-021 SHALL cover these directed scenarios:
- I-type, Opcode=0010011, Rd=1, Rs1=0, Funct3=0, Imm=5 -> InstrOut=0x00500093, ImmErr=0, out_valid one cycle after accept.
- S-type, Opcode=0100011, Funct3=010, Rs1=1, Rs2=2, Imm=8 -> 0x0020A423; U-type, Opcode=0110111, Rd=5, Imm=0x12345000 -> 0x123452B7.
- J-type, Opcode=1101111, Rd=1, Imm=8 -> 0x008000EF; B-type with Imm=3 -> ImmErr=1; ImmSrc=111 -> InstrOut=0, ImmErr=1.
- out_ready=0, three back-to-back sets -> in_ready=0 after the 2nd accept, 3rd held; out_ready=1 -> all three delivered in order, EncCount=3.
- Occupancy 1, simultaneous push and pop for 10 cycles -> occupancy stays 1, one word per cycle, no loss.
- rst_n pulsed low with 2 entries buffered -> out_valid=0 and EncCount=0 immediately, in_ready=1.
